// File: rtl/mds_gf16_pkg.sv
// GF(2^4) arithmetic (poly x^4+x+1) and the byte-wide MDS mixing map and its inverse.
package mds_gf16_pkg;

  typedef logic [3:0] nibble_t;

  localparam nibble_t     GF16_POLY = 4'h3;
  localparam int unsigned BUF_DEPTH = 2;

  function automatic nibble_t gf16_mul2(input nibble_t x);
    return {x[2:0], 1'b0} ^ (x[3] ? GF16_POLY : 4'h0);
  endfunction

  function automatic nibble_t gf16_mul5(input nibble_t x);
    return gf16_mul2(gf16_mul2(x)) ^ x;
  endfunction

  // {a,b} -> {5a ^ 2b, 2a ^ b}
  function automatic logic [7:0] mds_fwd(input logic [7:0] v);
    nibble_t a;
    nibble_t b;
    a = v[7:4];
    b = v[3:0];
    return {gf16_mul5(a) ^ gf16_mul2(b), gf16_mul2(a) ^ b};
  endfunction

  // {H,L} -> {H ^ 2L, 2H ^ 5L}
  function automatic logic [7:0] mds_inv(input logic [7:0] v);
    nibble_t h;
    nibble_t l;
    h = v[7:4];
    l = v[3:0];
    return {h ^ gf16_mul2(l), gf16_mul2(h) ^ gf16_mul5(l)};
  endfunction

endpackage

// File: rtl/mds_inv_core.sv
// Combinational byte-wide inverse MDS transform.
module mds_inv_core
  import mds_gf16_pkg::*;
(
  input  logic [7:0] din,
  output logic [7:0] dout_c
);

  assign dout_c = mds_inv(din);

endmodule

// File: rtl/mds_inv_stream.sv
// Streaming inverse MDS with valid/ready handshake, optional raw-byte stage, 2-entry output
// buffer and delivered-byte counter. Optional self-check: define MDS_INV_SELFCHECK_EN.
module mds_inv_stream
  import mds_gf16_pkg::*;
#(
  parameter int unsigned PIPE_STAGES = 1,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [7:0]       D_IN,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [7:0]       D_OUT,
  output logic [CNT_W-1:0] BYTE_CNT,
  output logic             SELF_ERR
);

  localparam int unsigned OCC_W = 3;
  // Slots that can hold a byte: the output buffer plus any raw-byte stage ahead of it.
  localparam int unsigned CAP   = BUF_DEPTH + PIPE_STAGES - 1;

  logic [1:0]       cnt_q, cnt_d;
  logic [7:0]       head_d, tail_q, tail_d;
  logic             in_fire_c, pop_c, buf_room_c, up_v_c, push_c;
  logic [7:0]       core_in_c, core_out_c;
  logic [OCC_W-1:0] inflight_next_c;

  assign in_fire_c  = IN_VALID & IN_READY;
  assign pop_c      = OUT_VALID & OUT_READY;
  assign buf_room_c = (cnt_q != 2'd2) | pop_c;
  assign push_c     = up_v_c & buf_room_c;

  generate
    if (PIPE_STAGES == 2) begin : g_stage2
      logic       s_v_q;
      logic [7:0] s_d_q;
      logic       s_rdy_c;

      assign s_rdy_c = ~s_v_q | buf_room_c;

      // Raw-byte stage; the transform sits between this register and the buffer.
      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
          s_v_q <= 1'b0;
          s_d_q <= 8'h00;
        end else if (s_rdy_c) begin
          s_v_q <= in_fire_c;
          if (in_fire_c) s_d_q <= D_IN;
        end
      end

      assign up_v_c          = s_v_q;
      assign core_in_c       = s_d_q;
      assign inflight_next_c = OCC_W'(s_rdy_c ? in_fire_c : s_v_q);
    end else begin : g_stage1
      assign up_v_c          = in_fire_c;
      assign core_in_c       = D_IN;
      assign inflight_next_c = '0;
    end
  endgenerate

  mds_inv_core u_core (
    .din    (core_in_c),
    .dout_c (core_out_c)
  );

  // Output buffer: D_OUT is the head register, so it holds its value whenever nothing pops.
  always_comb begin
    cnt_d  = cnt_q;
    head_d = D_OUT;
    tail_d = tail_q;
    case ({push_c, pop_c})
      2'b10: begin
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd0) head_d = core_out_c;
        else               tail_d = core_out_c;
      end
      2'b01: begin
        cnt_d = cnt_q - 2'd1;
        if (cnt_q == 2'd2) head_d = tail_q;
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          head_d = core_out_c;
        end else begin
          head_d = tail_q;
          tail_d = core_out_c;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q     <= 2'd0;
      D_OUT     <= 8'h00;
      tail_q    <= 8'h00;
      OUT_VALID <= 1'b0;
      IN_READY  <= 1'b0;
      BYTE_CNT  <= '0;
    end else begin
      cnt_q     <= cnt_d;
      D_OUT     <= head_d;
      tail_q    <= tail_d;
      OUT_VALID <= (cnt_d != 2'd0);
      // Ready only if one more accept next cycle still fits even with no pop.
      IN_READY  <= (OCC_W'(cnt_d) + inflight_next_c) < OCC_W'(CAP);
      if (pop_c) BYTE_CNT <= BYTE_CNT + CNT_W'(1);
    end
  end

`ifdef MDS_INV_SELFCHECK_EN
  logic [7:0] orig_head_q, orig_head_d, orig_tail_q, orig_tail_d;
  logic       self_err_q;

  // Original input bytes travel in lockstep with their results.
  always_comb begin
    orig_head_d = orig_head_q;
    orig_tail_d = orig_tail_q;
    case ({push_c, pop_c})
      2'b10: begin
        if (cnt_q == 2'd0) orig_head_d = core_in_c;
        else               orig_tail_d = core_in_c;
      end
      2'b01: begin
        if (cnt_q == 2'd2) orig_head_d = orig_tail_q;
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          orig_head_d = core_in_c;
        end else begin
          orig_head_d = orig_tail_q;
          orig_tail_d = core_in_c;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      orig_head_q <= 8'h00;
      orig_tail_q <= 8'h00;
      self_err_q  <= 1'b0;
    end else begin
      orig_head_q <= orig_head_d;
      orig_tail_q <= orig_tail_d;
      if (pop_c && (mds_fwd(D_OUT) != orig_head_q)) self_err_q <= 1'b1;
    end
  end

  assign SELF_ERR = self_err_q;
`else
  assign SELF_ERR = 1'b0;
`endif

endmodule
